// File: rtl/freq_duty_cfg_arbiter.sv
// Round-robin arbiter that serialises divider reconfiguration requests.
// Each legal update disables the divider, lets it settle, loads new counts, then re-enables it.
module freq_duty_cfg_arbiter #(
    parameter int unsigned Count_bits    = 8,
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DEF_DIV       = 4,
    parameter int unsigned DEF_DUTY      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_run,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*Count_bits-1:0] i_div_count_req,
    input  logic [N_REQ*Count_bits-1:0] i_duty_count_req,
    output logic [Count_bits-1:0]       o_div_count,
    output logic [Count_bits-1:0]       o_duty_count,
    output logic                        o_div_enable,
    output logic [N_REQ-1:0]            o_ack,
    output logic                        o_err,
    output logic                        o_busy,
    output logic [$clog2(N_REQ)-1:0]    o_owner
);

    localparam int unsigned OWN_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, QUIESCE, LOAD, ACK} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       settle_cnt;
    logic [Count_bits-1:0]  lat_div;
    logic [Count_bits-1:0]  lat_duty;

    logic                   hit_c;
    logic [OWN_W-1:0]       cand_c;
    logic [OWN_W-1:0]       grant_idx_c;
    logic [Count_bits-1:0]  grant_div_c;
    logic [Count_bits-1:0]  grant_duty_c;
    logic                   grant_legal_c;

    // First pending requester after the last owner, wrapping around.
    always_comb begin
        hit_c       = 1'b0;
        cand_c      = '0;
        grant_idx_c = o_owner;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand_c = OWN_W'((32'(o_owner) + i) % N_REQ);
            if (!hit_c && i_req[cand_c]) begin
                hit_c       = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        grant_div_c   = Count_bits'(i_div_count_req  >> (32'(grant_idx_c) * Count_bits));
        grant_duty_c  = Count_bits'(i_duty_count_req >> (32'(grant_idx_c) * Count_bits));
        grant_legal_c = (grant_div_c >= Count_bits'(2)) &&
                        (grant_duty_c >= Count_bits'(1)) &&
                        (grant_duty_c < grant_div_c);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            lat_div      <= '0;
            lat_duty     <= '0;
            o_div_count  <= Count_bits'(DEF_DIV);
            o_duty_count <= Count_bits'(DEF_DUTY);
            o_div_enable <= 1'b0;
            o_ack        <= '0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
            o_owner      <= OWN_W'(N_REQ - 1);
        end else begin
            o_ack <= '0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    o_div_enable <= i_run;
                    o_busy       <= 1'b0;
                    if (hit_c) begin
                        o_owner  <= grant_idx_c;
                        lat_div  <= grant_div_c;
                        lat_duty <= grant_duty_c;
                        o_busy   <= 1'b1;
                        if (grant_legal_c) begin
                            state        <= QUIESCE;
                            settle_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                            o_div_enable <= 1'b0;
                        end else begin
                            // Rejected pair: acknowledge with error, divider keeps running.
                            state <= ACK;
                            o_ack <= N_REQ'(1) << grant_idx_c;
                            o_err <= 1'b1;
                        end
                    end
                end
                QUIESCE: begin
                    o_div_enable <= 1'b0;
                    if (settle_cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                LOAD: begin
                    // Counts change on the same edge enable may rise, never while enabled.
                    o_div_count  <= lat_div;
                    o_duty_count <= lat_duty;
                    o_div_enable <= i_run;
                    o_ack        <= N_REQ'(1) << o_owner;
                    state        <= ACK;
                end
                ACK: begin
                    o_div_enable <= i_run;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_duty_cfg_arbiter.md
Name: freq_duty_cfg_arbiter

Overview:
Shares the single frequency/duty divider between N_REQ configuration requesters, such as a host register interface, a calibration engine and a test controller.
- Arbitrates pending reconfiguration requests round-robin.
- Rejects illegal count pairs.
- Sequences each legal update glitch-safely: disable divider, settle, load new counts, re-enable, acknowledge.
- Sits between the requesters and the divider's count and enable inputs, clocked from the same base clock as the divider.

Parameters:
Count_bits, 8, width of div/duty counts (matches divider)
N_REQ, 4, number of requesters (2..16)
SETTLE_CYCLES, 4, cycles divider is held disabled before load (>=1)
DEF_DIV, 4, o_div_count reset value (must satisfy the legality rule)
DEF_DUTY, 2, o_duty_count reset value

Ports:
i_clk  in  1  base clock
i_rst  in  1  async active-high reset
i_run  in  1  global divider run request
i_req  in  N_REQ  level request per requester; held until its o_ack
i_div_count_req  in  N_REQ*Count_bits  requester k at [k*Count_bits +: Count_bits]
i_duty_count_req  in  N_REQ*Count_bits  same packing
o_div_count  out  Count_bits  to divider
o_duty_count  out  Count_bits  to divider
o_div_enable  out  1  to divider enable
o_ack  out  N_REQ  one-hot, 1-cycle pulse; transaction complete
o_err  out  1  1-cycle pulse with o_ack; request rejected
o_busy  out  1  high in QUIESCE/LOAD/ACK
o_owner  out  $clog2(N_REQ)  index of last granted requester

Behaviour:
- Reset (async assert, sync deassert handled upstream) drives these values:
  - state IDLE
  - o_div_count=DEF_DIV, o_duty_count=DEF_DUTY
  - o_div_enable=0, o_ack=0, o_err=0, o_busy=0
  - o_owner=N_REQ-1, so requester 0 has first priority
- All outputs are registered.
- States: IDLE, QUIESCE, LOAD, ACK.
- IDLE:
  - o_div_enable follows i_run with 1-cycle lag.
  - If any i_req bit is set, grant the first set bit searching (o_owner+1) mod N_REQ upward with wrap.
  - Latch the grant index into o_owner and latch the winner's counts.
- Legality rule: div>=2 AND duty>=1 AND duty<div, unsigned Count_bits compare.
- Grant of an illegal pair:
  - Next state ACK with o_err=1.
  - Divider is untouched; enable is not dropped.
  - Pointer still advances.
- Grant of a legal pair:
  - Next state QUIESCE; o_div_enable=0 from the next cycle.
  - Settle counter loaded with SETTLE_CYCLES-1.
- QUIESCE: decrement the counter each cycle; at 0 go to LOAD. The state lasts exactly SETTLE_CYCLES cycles.
- LOAD: o_div_count and o_duty_count take the latched values on the edge leaving LOAD; next state ACK.
- ACK:
  - o_ack[o_owner]=1 for exactly one cycle; o_div_enable=i_run.
  - No arbitration in this cycle. Next state IDLE.
  - Requesters drop i_req the cycle after ack.
- Latency from the grant edge:
  - Legal: o_ack high in cycle SETTLE_CYCLES+2; new counts visible in the ACK cycle; enable low for SETTLE_CYCLES+1 cycles.
  - Illegal: o_ack+o_err high in cycle 1.
- Changes to i_req and count inputs after grant are ignored (latched). A withdrawn request still completes and is still acked.
- i_run low: o_div_enable stays 0 throughout; the sequence still runs; counts still load.
- Simultaneous requests are served one per transaction in round-robin order; no requester is starved. Worst-case wait is (N_REQ-1) transactions.
- o_owner wraps from N_REQ-1 to 0.
- Reset mid-transaction: immediate return to reset values, with no ack and no partial count update. Requesters must re-request.
- o_div_count and o_duty_count never change while o_div_enable=1.

Test Plan:
- Reset then i_run=1, no req -> o_div_count=4, o_duty_count=2; o_div_enable=1 one cycle after i_run; o_owner=3.
- Legal update: i_req=0001, div=10, duty=3, SETTLE=4 -> enable low 5 cycles; counts become 10/3 in the ACK cycle; o_ack=0001 at cycle 6 after grant; o_err=0.
- Illegal requests: req0 with div=5, duty=5, then req0 with div=1, duty=0 -> each gives o_ack=0001 with o_err=1 at cycle 1; enable never drops; counts stay 4/2.
- Contention: i_req=1111 held, each dropped after its ack -> grants in order 0,1,2,3; then req3+req0 -> 0 before 3; o_owner wraps correctly.
- Reset mid-op: assert i_rst in QUIESCE cycle 2 -> all outputs at reset values immediately; no ack ever issued; the later request completes normally.
- i_run=0 during a legal update of req2 (div=200, duty=100) -> counts load; o_ack=0100; o_div_enable stays 0 throughout; o_div_count/o_duty_count never change while enable=1 (assertion).
